obc_shift_acc: RTL

Bit-serial shift-accumulator for the OBC 16-point DFT datapath; sits directly downstream of the per-bin real/imag OBC ROM stages. Each cycle it takes the two 32-bit ROM partial-sum words for one input bit-plane, most significant bit-plane first. It combines them into a signed accumulator with the sign-plane weighted negatively and adds a pre-scaled offset term. It then presents one full-precision DFT output coefficient with a single-cycle valid strobe. It also drives the bit-plane index that upstream input shift registers use to select the bits feeding the ROMs.

---
 rtl/obc_shift_acc_if.sv | 31 +++
 rtl/obc_shift_acc.sv | 103 ++++++++++
 2 files changed

// File: rtl/obc_shift_acc_if.sv
// obc_shift_acc bus: start/ROM handshake in,
// bit-plane index and result out.
interface obc_shift_acc_if #(
  parameter int W  = 32,
  parameter int B  = 16,
  parameter int AW = W + B + 2
);
  logic                   start;
  logic                   rom_valid;
  logic [W-1:0]           rom_in0;
  logic [W-1:0]           rom_in1;
  logic [W-1:0]           offset;
  logic [$clog2(B)-1:0]   bit_idx;
  logic                   busy;
  logic [AW-1:0]          y_out;
  logic                   out_valid;

  modport master (
    output start, rom_valid,
    output rom_in0, rom_in1, offset,
    input  bit_idx, busy,
    input  y_out, out_valid
  );

  modport slave (
    input  start, rom_valid,
    input  rom_in0, rom_in1, offset,
    output bit_idx, busy,
    output y_out, out_valid
  );
endinterface

// File: rtl/obc_shift_acc.sv
// Bit-serial OBC shift-accumulator: MSB
// (sign) plane first, then offset add.
module obc_shift_acc #(
  parameter int W  = 32,
  parameter int B  = 16,
  parameter int AW = W + B + 2
) (
  input  logic            clk,
  input  logic            rst,
  obc_shift_acc_if.slave  bus
);
  localparam int IW = $clog2(B);
  localparam logic [IW-1:0] IDX_MSB = IW'(B - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OFFS,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AW-1:0]     y_q, y_d;
  logic [IW-1:0]     idx_q, idx_d;

  logic [W:0]        p;
  logic [AW-1:0]     p_ext;
  logic [AW-1:0]     off_ext;

  // Sum of the two ROM words, one guard bit wide.
  always_comb begin
    p       = {bus.rom_in0[W-1], bus.rom_in0}
            + {bus.rom_in1[W-1], bus.rom_in1};
    p_ext   = {{(AW-W-1){p[W]}}, p};
    off_ext = {{(AW-W){bus.offset[W-1]}},
               bus.offset};
  end

  // State, accumulator, index and result regs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      y_q     <= '0;
      idx_q   <= IDX_MSB;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: sign plane is negated, others
  // shift-and-add; stalls hold everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    y_d     = y_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ACC;
          acc_d   = '0;
          idx_d   = IDX_MSB;
        end
      end
      S_ACC: begin
        if (bus.rom_valid) begin
          if (idx_q == IDX_MSB) begin
            acc_d = '0 - p_ext;
          end else begin
            acc_d = (acc_q << 1) + p_ext;
          end
          if (idx_q == '0) begin
            state_d = S_OFFS;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      S_OFFS: begin
        y_d     = acc_q + off_ext;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = IDX_MSB;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.bit_idx   = idx_q;
  assign bus.y_out     = y_q;
  assign bus.busy      = (state_q == S_ACC)
                      || (state_q == S_OFFS);
  assign bus.out_valid = (state_q == S_DONE);
endmodule
